alu_share_arb: RTL
==================

ALU_SHARE_ARB -- requirements
Module: alu_share_arb

Interface
REQ-001 SHALL have parameter WIDTH, default 32, giving the operand and result width in bits.
REQ-002 SHALL have port clock  input  1  the single clock; all state updates on its rising edge.
REQ-003 SHALL have port reset  input  1  reset, synchronous and active-low.
REQ-004 SHALL have port req0_valid  input  1  requester 0 has an operation pending.
REQ-005 SHALL have port req0_ready  output  1  requester 0 operation accepted this cycle.
REQ-006 SHALL have ports req0_a, req0_b  input  WIDTH  requester 0 operands.
REQ-007 SHALL have port req0_op  input  2  requester 0 opcode.
REQ-008 SHALL have ports req1_valid, req1_ready, req1_a, req1_b and req1_op, identical in direction and width to the requester 0 ports, for requester 1.
REQ-009 SHALL have port resp_valid  output  1  result register holds an undelivered result.
REQ-010 SHALL have port resp_id  output  1  requester that owns the held result.
REQ-011 SHALL have port resp_data  output  WIDTH  held result.
REQ-012 SHALL have port resp_ready  input  1  consumer takes the result this cycle.

Function
REQ-013 SHALL compute bitwise per bit i: op 00 -> A&B, 01 -> A|B, 10 -> A^B, 11 -> ~(A|B).
REQ-014 SHALL implement two states: IDLE (result register empty) and HOLD (result register full).
REQ-015 SHALL, in IDLE, grant exactly one requester when at least one reqN_valid is 1: the sole valid requester, or the requester named by the priority pointer when both are valid.
REQ-016 SHALL drive reqN_ready = 1 only in IDLE and only for the granted requester; the value is combinational from state, pointer and the valid inputs.
REQ-017 SHALL treat a cycle with reqN_valid & reqN_ready as the accept: capture the op result into resp_data and N into resp_id, then enter HOLD on the next edge.
REQ-018 SHALL assert resp_valid in HOLD only, so the result appears exactly 1 cycle after the accept.
REQ-019 SHALL keep resp_data and resp_id stable while resp_valid = 1 and resp_ready = 0.
REQ-020 SHALL return HOLD -> IDLE on an edge where resp_ready = 1; no new request is accepted in that same cycle, giving a peak throughput of one operation per 2 cycles.
REQ-021 SHALL, after each accept of requester N, set the priority pointer to 1-N; the pointer is unchanged in cycles without an accept.
REQ-022 SHALL hold both reqN_ready at 0 throughout HOLD, regardless of the valid inputs.
REQ-023 SHALL ignore resp_ready while in IDLE.
REQ-024 SHALL ignore the operands and opcode of requesters that are not granted.
REQ-025 SHALL let a requester deassert reqN_valid before it is accepted; no accept and no state change results.

Reset
REQ-026 SHALL, on a clock edge with reset = 0, force state IDLE, pointer = 0, resp_valid = 0, resp_id = 0 and resp_data = 0.
REQ-027 SHALL drive req0_ready = 0 and req1_ready = 0 in any cycle where reset = 0.
REQ-028 SHALL, when reset is asserted in HOLD, discard the held result with no resp_valid pulse.
REQ-029 SHALL allow the first accept in the first cycle with reset = 1.

Verification
REQ-030 Bench SHALL cover: reset, then req0 alone with a=0xFFFF0000, b=0x0F0F0F0F, op=10 -> req0_ready=1 in that cycle; next cycle resp_valid=1, resp_id=0, resp_data=0xF0F00F0F.
REQ-031 Bench SHALL cover: both valid every cycle, resp_ready=1 -> grants alternate 0,1,0,1 with one accept every 2 cycles.
REQ-032 Bench SHALL cover: HOLD with resp_ready=0 for 5 cycles while req1_valid=1 -> req1_ready stays 0 and resp_data is constant; after resp_ready=1, req1 is accepted 1 cycle later.
REQ-033 Bench SHALL cover: all four opcodes with a=0xAAAA5555, b=0x0000FFFF -> 0x00005555, 0xAAAAFFFF, 0xAAAAAAAA, 0x55550000.
REQ-034 Bench SHALL cover: reset asserted in HOLD -> next cycle resp_valid=0 and resp_data=0; with both requesters valid, the first accept after reset goes to req0.

Source files
------------

// File: rtl/alu_share_arb.sv
// Purpose : two requesters share one bitwise ALU and a single result register.
// Latency : the result is visible on resp_* one cycle after the accept.
// Backpressure: resp_ready=0 holds the result and blocks both requesters.
//
// Ports:
//   clock, reset           - rising-edge clock; synchronous active-low reset
//   reqN_valid/reqN_ready  - request handshake, N = 0,1 (ready is combinational)
//   reqN_a, reqN_b, reqN_op- operands and opcode (00 and, 01 or, 10 xor, 11 nor)
//   resp_valid/resp_ready  - result handshake; resp_id names the owner
//   resp_data              - result held until taken
module alu_share_arb #(
  parameter int WIDTH = 32
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             req0_valid,
  output logic             req0_ready,
  input  logic [WIDTH-1:0] req0_a,
  input  logic [WIDTH-1:0] req0_b,
  input  logic [1:0]       req0_op,
  input  logic             req1_valid,
  output logic             req1_ready,
  input  logic [WIDTH-1:0] req1_a,
  input  logic [WIDTH-1:0] req1_b,
  input  logic [1:0]       req1_op,
  output logic             resp_valid,
  output logic             resp_id,
  output logic [WIDTH-1:0] resp_data,
  input  logic             resp_ready
);

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_HOLD = 1'b1
  } state_t;

  state_t           state_q, state_d;
  logic             ptr_q, ptr_d;
  logic             resp_id_q, resp_id_d;
  logic [WIDTH-1:0] resp_data_q, resp_data_d;

  logic             grant0, grant1;
  logic [WIDTH-1:0] sel_a, sel_b;
  logic [1:0]       sel_op;

  function automatic logic [WIDTH-1:0] alu_f(input logic [1:0] op,
                                             input logic [WIDTH-1:0] a,
                                             input logic [WIDTH-1:0] b);
    logic [WIDTH-1:0] r;
    case (op)
      2'b00:   r = a & b;
      2'b01:   r = a | b;
      2'b10:   r = a ^ b;
      default: r = ~(a | b);
    endcase
    return r;
  endfunction

  always_comb begin
    grant0      = 1'b0;
    grant1      = 1'b0;
    state_d     = state_q;
    ptr_d       = ptr_q;
    resp_id_d   = resp_id_q;
    resp_data_d = resp_data_q;

    case (state_q)
      ST_IDLE: begin
        // Gating on reset keeps both readies low during reset, so no
        // requester can believe it was accepted while the block is cleared.
        if (reset) begin
          if (req0_valid && req1_valid) begin
            grant0 = ~ptr_q;
            grant1 = ptr_q;
          end else begin
            grant0 = req0_valid;
            grant1 = req1_valid;
          end
        end
        if (grant0 || grant1) begin
          state_d     = ST_HOLD;
          resp_id_d   = grant1;
          resp_data_d = alu_f(sel_op, sel_a, sel_b);
          // Loser of this accept gets priority next time.
          ptr_d       = ~grant1;
        end
      end
      ST_HOLD: begin
        // Release only; the freed register is not refilled in this cycle.
        if (resp_ready) begin
          state_d = ST_IDLE;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // Operand mux ahead of a single ALU; ungranted operands never reach it.
  always_comb begin
    sel_a  = req0_a;
    sel_b  = req0_b;
    sel_op = req0_op;
    if (grant1) begin
      sel_a  = req1_a;
      sel_b  = req1_b;
      sel_op = req1_op;
    end
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      state_q     <= ST_IDLE;
      ptr_q       <= 1'b0;
      resp_id_q   <= 1'b0;
      resp_data_q <= '0;
    end else begin
      state_q     <= state_d;
      ptr_q       <= ptr_d;
      resp_id_q   <= resp_id_d;
      resp_data_q <= resp_data_d;
    end
  end

  assign req0_ready = grant0;
  assign req1_ready = grant1;
  assign resp_valid = (state_q == ST_HOLD);
  assign resp_id    = resp_id_q;
  assign resp_data  = resp_data_q;

endmodule
